// File: rtl/softmax_stream_max_subtract.sv
// Softmax front-end: buffers an N_CH-element frame, tracks its maximum, then
// streams saturated (x_i - max) differences with index/last tags under backpressure.
module softmax_stream_max_subtract #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INTEGER    = 16,
    parameter int unsigned FRACTION   = 16,
    parameter int unsigned N_CH       = 4,
    localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(N_CH + 1);
    // Width mismatch here flags an inconsistent INTEGER/FRACTION split.
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(INTEGER + FRACTION - 1){1'b0}}};

    typedef enum logic [0:0] {S_LOAD, S_DRAIN} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      wr_cnt, wr_cnt_nxt;
    logic [CNT_W-1:0]      rd_cnt, rd_cnt_nxt;
    logic                  accept, load_out, done;
    logic [DATA_WIDTH-1:0] mem [N_CH];
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_elem;
    logic signed [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH-1:0] sat_diff;

    assign rd_idx  = rd_cnt[IDX_W-1:0];
    assign rd_elem = mem[rd_idx];

    // One extra bit keeps the difference exact; only negative overflow is possible.
    assign diff     = $signed({rd_elem[DATA_WIDTH-1], rd_elem}) - $signed({max_out[DATA_WIDTH-1], max_out});
    assign sat_diff = (diff[DATA_WIDTH] && !diff[DATA_WIDTH-1]) ? MOST_NEG : diff[DATA_WIDTH-1:0];

    // Next-state and handshake decode; flush discards any concurrent handshake.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        accept     = 1'b0;
        load_out   = 1'b0;
        done       = 1'b0;
        if (flush) begin
            state_nxt  = S_LOAD;
            wr_cnt_nxt = '0;
            rd_cnt_nxt = '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (wr_cnt == IDX_W'(N_CH - 1)) begin
                            wr_cnt_nxt = '0;
                            state_nxt  = S_DRAIN;
                        end else begin
                            wr_cnt_nxt = wr_cnt + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    done     = out_valid && out_ready && out_last;
                    load_out = (!out_valid || out_ready) && (rd_cnt < CNT_W'(N_CH));
                    if (load_out) begin
                        rd_cnt_nxt = rd_cnt + CNT_W'(1);
                    end
                    if (done) begin
                        rd_cnt_nxt = '0;
                        state_nxt  = S_LOAD;
                    end
                end
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_LOAD;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            rd_cnt   <= rd_cnt_nxt;
            in_ready <= (state_nxt == S_LOAD);
            busy     <= (wr_cnt_nxt != '0) || (state_nxt == S_DRAIN);
        end
    end

    // Frame buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt] <= in_data;
        end
    end

    // Running maximum and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_out   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (wr_cnt == '0 || $signed(in_data) > $signed(max_out)) begin
                    max_out <= in_data;
                end
            end
            if (flush) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= sat_diff;
                out_index <= rd_idx;
                out_last  <= (rd_cnt == CNT_W'(N_CH - 1));
            end else if (done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/softmax_stream_max_subtract.md
Name: softmax_stream_max_subtract

Overview:
- Parametrised successor to the fixed 4-input softmax front-end: the stage ahead of the exp units, for any channel count.
- Accepts a frame of N_CH signed fixed-point scores serially over a valid/ready stream, buffers them, and finds the frame maximum internally instead of taking it as a port.
- Then streams out the saturated differences x_i - max, one per handshake, into a single time-shared exp unit.
- Adds backpressure, per-element index/last tagging and a synchronous flush.

Parameters:
- DATA_WIDTH, 32, total bits of a two's-complement fixed-point element.
- INTEGER, 16, integer bits including sign (INTEGER + FRACTION == DATA_WIDTH).
- FRACTION, 16, fraction bits; passed through only, no rescaling performed.
- N_CH, 4, elements per frame, >= 2; buffer depth. Index width is clog2(N_CH) (min 1), derived internally.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of the current frame
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  DATA_WIDTH  signed score x_i
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  saturated x_i - max
- out_index  out  clog2(N_CH)  element position i in frame
- out_last  out  1  high with element N_CH-1
- max_out  out  DATA_WIDTH  frame maximum
- busy  out  1  high from first accepted element until last output handshake

Behaviour:
- Reset (reset low, async): state LOAD, all counters 0, buffer contents don't-care. Outputs: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, max_out=0, busy=0.
- FSM has two states, LOAD and DRAIN.
- LOAD:
  - in_ready=1.
  - Accept on in_valid && in_ready: buf[wr_cnt] <= in_data; wr_cnt++.
  - max register: loaded with in_data when wr_cnt==0, else becomes signed max(max, in_data). Ties keep the value.
  - On acceptance with wr_cnt==N_CH-1: wr_cnt <= 0, go to DRAIN. in_ready drops the next cycle.
- DRAIN:
  - in_ready=0.
  - Output register loads when (!out_valid || out_ready) and rd_cnt < N_CH: out_data <= sat(buf[rd_cnt] - max), out_index <= rd_cnt, out_last <= (rd_cnt==N_CH-1), out_valid <= 1, rd_cnt++.
  - When out_valid && out_ready && out_last: out_valid <= 0, rd_cnt <= 0, go to LOAD. in_ready is 1 the next cycle.
- Latency and throughput:
  - First out_valid is high 2 cycles after the cycle that accepted the last input.
  - With out_ready held high, one output per cycle; a frame drains in N_CH+1 cycles after the last accept.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Arithmetic:
  - Subtraction is computed at DATA_WIDTH+1 bits.
  - Results below -2^(DATA_WIDTH-1) clamp to 1 followed by all zeros (most negative).
  - A positive result cannot occur; the result is always <= 0.
- max_out is updated on every accept during LOAD and holds its final value through DRAIN until the next frame's first accept.
- busy = (wr_cnt != 0) || state==DRAIN.
- Flush:
  - flush=1 at a clock edge forces: state LOAD, wr_cnt=rd_cnt=0, out_valid=0, out_last=0, busy=0. max_out is held.
  - Flush overrides any simultaneous input or output handshake; that handshake is discarded.
- Reset mid-frame: the partial frame is dropped and no output is produced.
- in_valid during DRAIN is ignored (in_ready=0).
- out_ready while out_valid=0 has no effect.

Test Plan:
- Q16.16, N_CH=4.
  - Stimulus: inputs 0x00010000, 0x00030000, 0xFFFE0000, 0x00030000; out_ready=1.
  - Response: max_out=0x00030000; outputs 0xFFFE0000, 0x00000000, 0xFFFB0000, 0x00000000; indices 0..3; out_last only on index 3; first out_valid 2 cycles after the 4th accept.
- All-negative frame.
  - Stimulus: inputs 0xFFFF0000, 0xFFFC0000, 0xFFFE0000, 0xFFFD0000.
  - Response: max_out=0xFFFF0000; outputs 0, 0xFFFD0000, 0xFFFF0000, 0xFFFE0000.
- Saturation.
  - Stimulus: inputs 0x80000000, 0x7FFFFFFF, 0, 0.
  - Response: outputs 0x80000000, 0x00000000, 0x80000001, 0x80000001.
- Backpressure.
  - Stimulus: out_ready low 3 cycles at index 1, then toggled every cycle.
  - Response: out_data/out_index stable while stalled; no element lost or duplicated; in_ready=0 throughout DRAIN; in_ready=1 the cycle after the last handshake.
- Flush and reset.
  - Flush after 2 accepts, then a full new frame: outputs reflect only the new frame.
  - Flush at index 2 of DRAIN: out_valid=0 next cycle, in_ready=1.
  - reset low mid-DRAIN: all outputs return to reset values immediately.
- Back-to-back frames with N_CH=5 and in_valid held high.
  - Response: the second frame is accepted starting the cycle after the first frame's final output handshake; both frames produce correct differences.
